// File: rtl/csel_pkg.sv
// Shared definitions for the pipelined carry-select adder.
// Holds the op encodings and the block-count helper.
package csel_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;

    function automatic int calc_nblk(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder.
// Ports: a, b, cin in; sum, cout out.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csel_block.sv
// One carry-select block: two BLK-bit ripples, carry-in 0 and 1.
// Ports: a_blk, b_blk in; s0/s1 sums, c0/c1 carries, t0/t1 top-bit carry-ins out.
module csel_block #(
    parameter int BLK = 2
) (
    input  logic [BLK-1:0] a_blk,
    input  logic [BLK-1:0] b_blk,
    output logic [BLK-1:0] s0,
    output logic [BLK-1:0] s1,
    output logic           c0,
    output logic           c1,
    output logic           t0,
    output logic           t1
);

    logic [BLK:0] w_k0;
    logic [BLK:0] w_k1;

    assign w_k0[0] = 1'b0;
    assign w_k1[0] = 1'b1;

    for (genvar i = 0; i < BLK; i++) begin : g_bit
        Full_Adder u_fa0 (
            .a    (a_blk[i]),
            .b    (b_blk[i]),
            .cin  (w_k0[i]),
            .sum  (s0[i]),
            .cout (w_k0[i+1])
        );
        Full_Adder u_fa1 (
            .a    (a_blk[i]),
            .b    (b_blk[i]),
            .cin  (w_k1[i]),
            .sum  (s1[i]),
            .cout (w_k1[i+1])
        );
    end

    assign c0 = w_k0[BLK];
    assign c1 = w_k1[BLK];
    assign t0 = w_k0[BLK-1];
    assign t1 = w_k1[BLK-1];

endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage carry-select add/sub/adc with valid/ready on both sides.
// Ports: in_valid/in_ready, op, cin, a, b in; out_valid/out_ready, sum, cout, ovf out.
module csel_adder_pipe
    import csel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = calc_nblk(WIDTH, BLK);

    if (WIDTH % BLK != 0) begin : g_bad_width
        $error("csel_adder_pipe: WIDTH must be a multiple of BLK");
    end

    // operand conditioning
    logic [WIDTH-1:0] w_bc;
    logic             w_c0;

    always_comb begin
        w_bc = b;
        w_c0 = 1'b0;
        unique case (op)
            OP_SUB: begin
                w_bc = ~b;
                w_c0 = 1'b1;
            end
            OP_ADC:  w_c0 = cin;
            default: ;
        endcase
    end

    // block candidates
    logic [NBLK-1:0][BLK-1:0] w_s0;
    logic [NBLK-1:0][BLK-1:0] w_s1;
    logic [NBLK-1:0]          w_k0;
    logic [NBLK-1:0]          w_k1;
    logic [NBLK-1:0]          w_t0;
    logic [NBLK-1:0]          w_t1;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csel_block #(.BLK(BLK)) u_blk (
            .a_blk (a[k*BLK +: BLK]),
            .b_blk (w_bc[k*BLK +: BLK]),
            .s0    (w_s0[k]),
            .s1    (w_s1[k]),
            .c0    (w_k0[k]),
            .c1    (w_k1[k]),
            .t0    (w_t0[k]),
            .t1    (w_t1[k])
        );
    end

    // handshake
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_free;
    logic w_s1_move;
    logic w_accept;

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_move = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s1_move;
    assign w_accept  = in_valid && in_ready;

    // S1 registers
    logic [NBLK-1:0][BLK-1:0] r_s1_sum0;
    logic [NBLK-1:0][BLK-1:0] r_s1_sum1;
    logic [NBLK-1:0]          r_s1_c0;
    logic [NBLK-1:0]          r_s1_c1;
    logic [NBLK-1:0]          r_s1_t0;
    logic [NBLK-1:0]          r_s1_t1;
    logic                     r_s1_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum0  <= '0;
            r_s1_sum1  <= '0;
            r_s1_c0    <= '0;
            r_s1_c1    <= '0;
            r_s1_t0    <= '0;
            r_s1_t1    <= '0;
            r_s1_cin   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_move) begin
                r_s1_valid <= 1'b0;
            end
            if (w_accept) begin
                r_s1_sum0 <= w_s0;
                r_s1_sum1 <= w_s1;
                r_s1_c0   <= w_k0;
                r_s1_c1   <= w_k1;
                r_s1_t0   <= w_t0;
                r_s1_t1   <= w_t1;
                r_s1_cin  <= w_c0;
            end
        end
    end

    // select chain; w_ctop[k] is the chosen carry into block k's top bit,
    // only the last one matters (it feeds ovf)
    logic [NBLK:0]      w_csel;
    logic [NBLK-1:0]    w_ctop;
    logic [WIDTH-1:0]   w_sum;

    always_comb begin
        w_csel    = '0;
        w_ctop    = '0;
        w_sum     = '0;
        w_csel[0] = r_s1_cin;
        for (int k = 0; k < NBLK; k++) begin
            w_sum[k*BLK +: BLK] = w_csel[k] ? r_s1_sum1[k] : r_s1_sum0[k];
            w_ctop[k]           = w_csel[k] ? r_s1_t1[k] : r_s1_t0[k];
            w_csel[k+1]         = w_csel[k] ? r_s1_c1[k] : r_s1_c0[k];
        end
    end

    logic w_unused_ctop;
    assign w_unused_ctop = ^w_ctop;

    // S2 registers
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_s1_move) begin
                r_s2_valid <= 1'b1;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
            if (w_s1_move) begin
                r_sum  <= w_sum;
                r_cout <= w_csel[NBLK];
                r_ovf  <= w_ctop[NBLK-1] ^ w_csel[NBLK];
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe at 16/2 and 32/4.
// Drivers push expected results; negedge monitors pop and compare.
module tb_csel_adder_pipe;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        bit          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // DUT A: 16/2
    logic        va_in_valid = 1'b0;
    logic        va_in_ready;
    logic [1:0]  va_op = 2'b00;
    logic        va_cin = 1'b0;
    logic [15:0] va_a = '0;
    logic [15:0] va_b = '0;
    logic        va_out_valid;
    logic        va_out_ready = 1'b1;
    logic [15:0] va_sum;
    logic        va_cout;
    logic        va_ovf;

    // DUT B: 32/4
    logic        vb_in_valid = 1'b0;
    logic        vb_in_ready;
    logic [1:0]  vb_op = 2'b00;
    logic        vb_cin = 1'b0;
    logic [31:0] vb_a = '0;
    logic [31:0] vb_b = '0;
    logic        vb_out_valid;
    logic        vb_out_ready = 1'b1;
    logic [31:0] vb_sum;
    logic        vb_cout;
    logic        vb_ovf;

    csel_adder_pipe #(.WIDTH(16), .BLK(2)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (va_in_valid),
        .in_ready  (va_in_ready),
        .op        (va_op),
        .cin       (va_cin),
        .a         (va_a),
        .b         (va_b),
        .out_valid (va_out_valid),
        .out_ready (va_out_ready),
        .sum       (va_sum),
        .cout      (va_cout),
        .ovf       (va_ovf)
    );

    csel_adder_pipe #(.WIDTH(32), .BLK(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vb_in_valid),
        .in_ready  (vb_in_ready),
        .op        (vb_op),
        .cin       (vb_cin),
        .a         (vb_a),
        .b         (vb_b),
        .out_valid (vb_out_valid),
        .out_ready (vb_out_ready),
        .sum       (vb_sum),
        .cout      (vb_cout),
        .ovf       (vb_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t cur_a;
    exp_t cur_b;
    int   acc_a = 0;
    int   acc_b = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t ex(input logic [31:0] s, input logic c,
                                input logic o, input bit lat);
        exp_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = o;
        r.lat  = lat;
        r.acc  = 0;
        return r;
    endfunction

    // behavioural reference: wide integer add, carry into MSB from low part
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin,
                                   input int w);
        logic [63:0] m, mh, aa, bb, full, low, cc;
        exp_t r;
        m    = (64'd1 << w) - 64'd1;
        mh   = m >> 1;
        aa   = {32'd0, a} & m;
        bb   = (op == 2'b01) ? (~{32'd0, b}) & m : {32'd0, b} & m;
        cc   = (op == 2'b01) ? 64'd1 : (op == 2'b10) ? {63'd0, cin} : 64'd0;
        full = aa + bb + cc;
        low  = (aa & mh) + (bb & mh) + cc;
        r.sum  = full[31:0] & m[31:0];
        r.cout = full[w];
        r.ovf  = low[w-1] ^ full[w];
        r.lat  = 1'b0;
        r.acc  = 0;
        return r;
    endfunction

    // monitor A
    bit          hold_a = 0;
    logic [17:0] hval_a;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_a = 0;
        end else begin
            chk("a_in_ready", {31'd0, va_in_ready},
                (qa.size() == 2 && !va_out_ready) ? 32'd0 : 32'd1);
            if (hold_a) begin
                chk("a_hold_valid", {31'd0, va_out_valid}, 32'd1);
                chk("a_hold_data", {14'd0, va_cout, va_ovf, va_sum},
                    {14'd0, hval_a});
            end
            if (va_out_valid && va_out_ready) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_unexpected: sum=%h with no pending beat",
                             va_sum);
                end else begin
                    e = qa.pop_front();
                    chk("a_sum", {16'd0, va_sum}, e.sum);
                    chk("a_cout", {31'd0, va_cout}, {31'd0, e.cout});
                    chk("a_ovf", {31'd0, va_ovf}, {31'd0, e.ovf});
                    if (e.lat)
                        chk("a_latency", cyc - e.acc, 32'd2);
                end
            end
            hold_a = va_out_valid && !va_out_ready;
            hval_a = {va_cout, va_ovf, va_sum};
            if (va_in_valid && va_in_ready) begin
                e     = cur_a;
                e.acc = cyc;
                qa.push_back(e);
                acc_a++;
            end
        end
    end

    // monitor B
    bit          hold_b = 0;
    logic [33:0] hval_b;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_b = 0;
        end else begin
            chk("b_in_ready", {31'd0, vb_in_ready},
                (qb.size() == 2 && !vb_out_ready) ? 32'd0 : 32'd1);
            if (hold_b)
                chk("b_hold_sum", vb_sum, hval_b[31:0]);
            if (vb_out_valid && vb_out_ready) begin
                if (qb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_unexpected: sum=%h with no pending beat",
                             vb_sum);
                end else begin
                    e = qb.pop_front();
                    chk("b_sum", vb_sum, e.sum);
                    chk("b_cout", {31'd0, vb_cout}, {31'd0, e.cout});
                    chk("b_ovf", {31'd0, vb_ovf}, {31'd0, e.ovf});
                end
            end
            hold_b = vb_out_valid && !vb_out_ready;
            hval_b = {vb_cout, vb_ovf, vb_sum};
            if (vb_in_valid && vb_in_ready) begin
                e     = cur_b;
                e.acc = cyc;
                qb.push_back(e);
                acc_b++;
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_a(input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin,
                          input exp_t e);
        int start;
        int t;
        start       = acc_a;
        t           = 0;
        cur_a       = e;
        va_op       = op;
        va_a        = a;
        va_b        = b;
        va_cin      = cin;
        va_in_valid = 1'b1;
        do begin
            @(posedge clk);
            t++;
        end while (acc_a == start && t < 50);
        if (acc_a == start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_accept_timeout: got no accept expected one");
        end
        #1 va_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin);
        int start;
        int t;
        start       = acc_b;
        t           = 0;
        cur_b       = model(op, a, b, cin, 32);
        vb_op       = op;
        vb_a        = a;
        vb_b        = b;
        vb_cin      = cin;
        vb_in_valid = 1'b1;
        do begin
            @(posedge clk);
            t++;
        end while (acc_b == start && t < 50);
        if (acc_b == start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_accept_timeout: got no accept expected one");
        end
        #1 vb_in_valid = 1'b0;
    endtask

    bit b_run = 0;
    always @(posedge clk) begin
        #1;
        if (b_run)
            vb_out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, va_out_valid}, 32'd0);
        chk("rst_sum", {16'd0, va_sum}, 32'd0);
        chk("rst_cout", {31'd0, va_cout}, 32'd0);
        chk("rst_ovf", {31'd0, va_ovf}, 32'd0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", {31'd0, va_in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // directed vectors, out_ready high, latency checked
        send_a(2'b00, 16'hFFFF, 16'h0001, 1'b0, ex(32'h0000, 1, 0, 1));
        send_a(2'b00, 16'h7FFF, 16'h0001, 1'b0, ex(32'h8000, 0, 1, 1));
        send_a(2'b01, 16'h8000, 16'h0001, 1'b0, ex(32'h7FFF, 1, 1, 1));
        send_a(2'b01, 16'h0005, 16'h0007, 1'b0, ex(32'hFFFE, 0, 0, 1));
        send_a(2'b10, 16'h1234, 16'h0001, 1'b1, ex(32'h1236, 0, 0, 1));
        send_a(2'b11, 16'h0001, 16'h0002, 1'b1, ex(32'h0003, 0, 0, 1));
        send_a(2'b00, 16'h00FF, 16'h0001, 1'b1, ex(32'h0100, 0, 0, 1));
        send_a(2'b01, 16'h0000, 16'h0000, 1'b0, ex(32'h0000, 1, 0, 1));
        repeat (3) @(posedge clk);
        #1;

        // 5-beat stream, out_ready low for cycles 2-4
        fork
            begin
                send_a(2'b00, 16'h0001, 16'h0001, 1'b0, ex(32'h0002, 0, 0, 0));
                send_a(2'b00, 16'h0010, 16'h0020, 1'b0, ex(32'h0030, 0, 0, 0));
                send_a(2'b01, 16'h0100, 16'h0001, 1'b0, ex(32'h00FF, 1, 0, 0));
                send_a(2'b10, 16'h8000, 16'h8000, 1'b0, ex(32'h0000, 1, 1, 0));
                send_a(2'b00, 16'h4000, 16'h4000, 1'b0, ex(32'h8000, 0, 1, 0));
            end
            begin
                va_out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 va_out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 va_out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // reset with two beats in flight
        va_out_ready = 1'b0;
        send_a(2'b00, 16'h1111, 16'h1111, 1'b0, ex(32'h2222, 0, 0, 0));
        send_a(2'b00, 16'h3333, 16'h1111, 1'b0, ex(32'h4444, 0, 0, 0));
        chk("pre_rst_valid", {31'd0, va_out_valid}, 32'd1);
        chk("pre_rst_in_ready", {31'd0, va_in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, va_out_valid}, 32'd0);
        chk("async_sum", {16'd0, va_sum}, 32'd0);
        chk("async_in_ready", {31'd0, va_in_ready}, 32'd1);
        qa.delete();
        va_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_a(2'b00, 16'h0A0A, 16'h0505, 1'b0, ex(32'h0F0F, 0, 0, 1));

        // random ops against the model on 16/2
        for (int i = 0; i < 12; i++) begin
            logic [1:0]  op;
            logic [15:0] ra, rb;
            logic        rc;
            op = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            send_a(op, ra, rb, rc, model(op, {16'd0, ra}, {16'd0, rb}, rc, 16));
        end

        t = 0;
        while (qa.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("a_drain_left", qa.size(), 32'd0);

        // random ops on 32/4 with random consumer stalls
        #1 b_run = 1;
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [31:0] ra, rb;
            logic        rc;
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            op = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i == 0) begin
                ra = 32'hFFFF_FFFF;
                rb = 32'h0000_0001;
                op = 2'b00;
            end
            if (i == 1) begin
                ra = 32'h8000_0000;
                rb = 32'h0000_0001;
                op = 2'b01;
            end
            rc = 1'($urandom_range(0, 1));
            send_b(op, ra, rb, rc);
        end

        t = 0;
        while (qb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("b_drain_left", qb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
